pkt_lane_identifier: RTL

PKT_LANE_IDENTIFIER -- requirements
Module: pkt_lane_identifier

---
 rtl/pkt_lane_identifier.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/pkt_lane_identifier.sv
// Multi-lane PCIe-style framing classifier: tags each byte lane as start/end/data/invalid.
// Optional TLP/DLLP length checking is enabled by defining PKT_LANE_LEN_CHECK_EN.

package pkt_lane_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_TLP  = 2'b01,
        ST_DLLP = 2'b10
    } pkt_state_t;

    localparam logic [2:0] T_DATA  = 3'b000;
    localparam logic [2:0] T_TSTRT = 3'b001;
    localparam logic [2:0] T_TEND  = 3'b010;
    localparam logic [2:0] T_DSTRT = 3'b011;
    localparam logic [2:0] T_DEND  = 3'b100;
    localparam logic [2:0] T_TEDB  = 3'b101;
    localparam logic [2:0] T_INV   = 3'b111;

    localparam logic [7:0] K_STP = 8'hFB;
    localparam logic [7:0] K_SDP = 8'h5C;
    localparam logic [7:0] K_END = 8'hFD;
    localparam logic [7:0] K_EDB = 8'hFE;
    localparam logic [7:0] K_PAD = 8'hF7;
endpackage

// One lane of the classification chain: consumes the context left by the previous lane.
module pkt_lane_cls
    import pkt_lane_pkg::*;
`ifdef PKT_LANE_LEN_CHECK_EN
#(
    parameter int MAX_TLP = 4096,
    parameter int CW      = $clog2(MAX_TLP + 2)
)
`endif
(
    input  logic [7:0]    sym,
    input  logic          is_k,
    input  pkt_state_t    st_i,
    output pkt_state_t    st_o,
`ifdef PKT_LANE_LEN_CHECK_EN
    input  logic [CW-1:0] cnt_i,
    output logic [CW-1:0] cnt_o,
`endif
    output logic [2:0]    typ,
    output logic          tlp_end,
    output logic          dllp_end,
    output logic          err
);
    always_comb begin
        typ      = T_INV;
        st_o     = st_i;
        tlp_end  = 1'b0;
        dllp_end = 1'b0;
        err      = 1'b0;
`ifdef PKT_LANE_LEN_CHECK_EN
        cnt_o    = cnt_i;
`endif
        if (is_k) begin
            case (sym)
                K_STP: begin
                    typ  = T_TSTRT;
                    err  = (st_i != ST_IDLE);
                    st_o = ST_TLP;
`ifdef PKT_LANE_LEN_CHECK_EN
                    cnt_o = '0;
`endif
                end
                K_SDP: begin
                    typ  = T_DSTRT;
                    err  = (st_i != ST_IDLE);
                    st_o = ST_DLLP;
`ifdef PKT_LANE_LEN_CHECK_EN
                    cnt_o = '0;
`endif
                end
                K_END: begin
                    st_o = ST_IDLE;
                    if (st_i == ST_TLP) begin
                        typ     = T_TEND;
                        tlp_end = 1'b1;
                    end else if (st_i == ST_DLLP) begin
                        typ = T_DEND;
`ifdef PKT_LANE_LEN_CHECK_EN
                        // Saturated counts never match, so oversized DLLPs still error.
                        if (32'(cnt_i) == 32'd6) dllp_end = 1'b1;
                        else                     err      = 1'b1;
`else
                        dllp_end = 1'b1;
`endif
                    end else begin
                        err = 1'b1;
                    end
                end
                K_EDB: begin
                    st_o = ST_IDLE;
                    if (st_i == ST_TLP) typ = T_TEDB;
                    else                err = 1'b1;
                end
                K_PAD: ;
                default: err = 1'b1;
            endcase
        end else if (st_i == ST_TLP) begin
`ifdef PKT_LANE_LEN_CHECK_EN
            if (32'(cnt_i) == MAX_TLP) begin
                err  = 1'b1;
                st_o = ST_IDLE;
            end else begin
                typ   = T_DATA;
                cnt_o = cnt_i + 1'b1;
            end
`else
            typ = T_DATA;
`endif
        end else if (st_i == ST_DLLP) begin
            typ = T_DATA;
`ifdef PKT_LANE_LEN_CHECK_EN
            if (cnt_i != '1) cnt_o = cnt_i + 1'b1;
`endif
        end
    end
endmodule

module pkt_lane_identifier
    import pkt_lane_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int MAX_TLP = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [8*LANES-1:0] data_in,
    input  logic [LANES-1:0]   dk_in,
    input  logic               valid_in,
    output logic [3*LANES-1:0] type_out,
    output logic               valid_out,
    output logic [1:0]         state_out,
    output logic               tlp_done,
    output logic               dllp_done,
    output logic               err_out
);
    if (LANES < 1 || LANES > 8 || MAX_TLP < 1) begin : g_param_chk
        $error("pkt_lane_identifier: LANES must be 1..8 and MAX_TLP >= 1");
    end

`ifdef PKT_LANE_LEN_CHECK_EN
    localparam int CW = $clog2(MAX_TLP + 2);
    logic [CW-1:0]            cnt_q, cnt_nxt;
    logic [LANES:0][CW-1:0]   cnt_c;
    assign cnt_c[0] = cnt_q;
`endif

    pkt_state_t               st_q, st_nxt;
    pkt_state_t               st_c [LANES:0];
    logic [LANES-1:0][2:0]    typ_c, typ_q;
    logic [LANES-1:0]         tlp_c, dllp_c, err_c;

    assign st_c[0] = st_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        pkt_lane_cls
`ifdef PKT_LANE_LEN_CHECK_EN
        #(.MAX_TLP(MAX_TLP), .CW(CW))
`endif
        u_lane (
            .sym      (data_in[8*k +: 8]),
            .is_k     (dk_in[k]),
            .st_i     (st_c[k]),
            .st_o     (st_c[k+1]),
`ifdef PKT_LANE_LEN_CHECK_EN
            .cnt_i    (cnt_c[k]),
            .cnt_o    (cnt_c[k+1]),
`endif
            .typ      (typ_c[k]),
            .tlp_end  (tlp_c[k]),
            .dllp_end (dllp_c[k]),
            .err      (err_c[k])
        );
    end

    // Context only advances on valid cycles; idle cycles hold state and count.
    always_comb begin
        st_nxt = st_q;
`ifdef PKT_LANE_LEN_CHECK_EN
        cnt_nxt = cnt_q;
`endif
        if (valid_in) begin
            st_nxt = st_c[LANES];
`ifdef PKT_LANE_LEN_CHECK_EN
            cnt_nxt = cnt_c[LANES];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q      <= ST_IDLE;
`ifdef PKT_LANE_LEN_CHECK_EN
            cnt_q     <= '0;
`endif
            typ_q     <= '1;
            valid_out <= 1'b0;
            tlp_done  <= 1'b0;
            dllp_done <= 1'b0;
            err_out   <= 1'b0;
        end else begin
            st_q      <= st_nxt;
`ifdef PKT_LANE_LEN_CHECK_EN
            cnt_q     <= cnt_nxt;
`endif
            valid_out <= valid_in;
            typ_q     <= valid_in ? typ_c : '1;
            tlp_done  <= valid_in & (|tlp_c);
            dllp_done <= valid_in & (|dllp_c);
            err_out   <= valid_in & (|err_c);
        end
    end

    assign type_out  = typ_q;
    assign state_out = st_q;
endmodule
